// File: rtl/interrupt_sequencer.sv
`default_nettype none
// ============================================================================
// interrupt_sequencer: merges RESET/NMI/IRQ/BRK into the 8227 opcode stream.
// Optional macro INT_COUNT_EN adds the intCount hardware-service counter.
// Revision: 1.0
// ============================================================================
module interrupt_sequencer #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [5:0] INT_INSTR   = 6'd0,
  parameter logic [3:0] INT_ADDR    = 4'd0,
  parameter logic [5:0] BRK_CODE    = 6'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enableFFs,
  input  logic       getInstruction,
  input  logic       nmi_n,
  input  logic       irq_n,
  input  logic       iFlag,
  input  logic [5:0] decodedInstruction,
  input  logic [3:0] decodedAddress,
  output logic [5:0] instructionOut,
  output logic [3:0] addressOut,
  output logic [1:0] vectorSel,
  output logic       serviceActive,
  output logic       suppressPC,
  output logic       suppressWrite,
  output logic       bFlag
`ifdef INT_COUNT_EN
  ,
  output logic [7:0] intCount
`endif
);

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_SERVICE = 1'b1} state_t;
  typedef enum logic [2:0] {
    SRC_NONE  = 3'd0,
    SRC_RESET = 3'd1,
    SRC_NMI   = 3'd2,
    SRC_IRQ   = 3'd3,
    SRC_BRK   = 3'd4
  } src_t;

  logic [SYNC_STAGES-1:0] nmi_sync_q;
  logic [SYNC_STAGES-1:0] irq_sync_q;
  logic                   nmi_prev_q;
  logic                   nmi_edge;
  logic                   irq_req;
  logic                   accept;
  logic                   hw_src;
  src_t                   src;

  state_t     state_q, state_d;
  logic       nmi_pending_q, nmi_pending_d;
  logic       reset_pending_q, reset_pending_d;
  logic [1:0] vector_sel_q, vector_sel_d;
  logic       suppress_pc_q, suppress_pc_d;
  logic       suppress_wr_q, suppress_wr_d;
  logic       bflag_q, bflag_d;

  // Synchronisers and edge detector run every clock so NMI edges survive stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nmi_sync_q <= '1;
      irq_sync_q <= '1;
      nmi_prev_q <= 1'b1;
    end else begin
      nmi_sync_q <= {nmi_sync_q[SYNC_STAGES-2:0], nmi_n};
      irq_sync_q <= {irq_sync_q[SYNC_STAGES-2:0], irq_n};
      nmi_prev_q <= nmi_sync_q[SYNC_STAGES-1];
    end
  end

  assign nmi_edge = nmi_prev_q & ~nmi_sync_q[SYNC_STAGES-1];
  assign irq_req  = ~irq_sync_q[SYNC_STAGES-1] & ~iFlag;
  assign accept   = getInstruction & enableFFs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_RUN;
      nmi_pending_q   <= 1'b0;
      reset_pending_q <= 1'b1;
      vector_sel_q    <= 2'd0;
      suppress_pc_q   <= 1'b0;
      suppress_wr_q   <= 1'b0;
      bflag_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      nmi_pending_q   <= nmi_pending_d;
      reset_pending_q <= reset_pending_d;
      vector_sel_q    <= vector_sel_d;
      suppress_pc_q   <= suppress_pc_d;
      suppress_wr_q   <= suppress_wr_d;
      bflag_q         <= bflag_d;
    end
  end

  always_comb begin
    src             = SRC_NONE;
    hw_src          = 1'b0;
    instructionOut  = decodedInstruction;
    addressOut      = decodedAddress;
    state_d         = state_q;
    nmi_pending_d   = nmi_pending_q;
    reset_pending_d = reset_pending_q;
    vector_sel_d    = vector_sel_q;
    suppress_pc_d   = suppress_pc_q;
    suppress_wr_d   = suppress_wr_q;
    bflag_d         = bflag_q;

    if (reset_pending_q)                       src = SRC_RESET;
    else if (nmi_pending_q)                    src = SRC_NMI;
    else if (irq_req)                          src = SRC_IRQ;
    else if (decodedInstruction == BRK_CODE)   src = SRC_BRK;
    hw_src = (src == SRC_RESET) || (src == SRC_NMI) || (src == SRC_IRQ);

    if (accept) begin
      if (hw_src) begin
        instructionOut = INT_INSTR;
        addressOut     = INT_ADDR;
      end
      state_d       = (src == SRC_NONE) ? ST_RUN : ST_SERVICE;
      suppress_pc_d = hw_src;
      suppress_wr_d = (src == SRC_RESET);
      bflag_d       = (src == SRC_BRK);
      case (src)
        SRC_RESET: vector_sel_d = 2'd1;
        SRC_NMI:   vector_sel_d = 2'd2;
        SRC_IRQ,
        SRC_BRK:   vector_sel_d = 2'd3;
        default:   vector_sel_d = 2'd0;
      endcase
      if (src == SRC_RESET) reset_pending_d = 1'b0;
      if (src == SRC_NMI)   nmi_pending_d   = 1'b0;
    end

    // A fresh edge in the accept cycle must not be swallowed by the clear.
    if (nmi_edge) nmi_pending_d = 1'b1;
  end

  assign vectorSel     = vector_sel_q;
  assign serviceActive = (state_q == ST_SERVICE);
  assign suppressPC    = suppress_pc_q;
  assign suppressWrite = suppress_wr_q;
  assign bFlag         = bflag_q;

`ifdef INT_COUNT_EN
  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (accept && hw_src && (count_q != 8'hFF)) count_d = count_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= 8'd0;
    else     count_q <= count_d;
  end

  assign intCount = count_q;
`endif

endmodule
`default_nettype wire

// File: doc/interrupt_sequencer.md
Name: interrupt_sequencer

Overview:
- Schedules hardware interrupts (RESET, NMI, IRQ) into the 8227 instruction stream.
- Sits between the opcode decoder and `state_machine`.
- At each instruction boundary it either passes the decoded opcode through, or substitutes the interrupt pseudo-instruction.
- In both cases it tells the datapath which vector to fetch and how to handle the PC, stack writes and the B flag.

Parameters:
- SYNC_STAGES, 2, synchroniser depth on `nmi_n` and `irq_n` (legal 2..4).
- INT_INSTR, 6'd0, instruction code substituted for a hardware interrupt.
- INT_ADDR, 4'd0, addressing code substituted for a hardware interrupt (implied).
- BRK_CODE, 6'd0, decoder code for software BRK.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- enableFFs  in  1  global advance enable; low = stall.
- getInstruction  in  1  high on the last cycle of the current instruction (boundary).
- nmi_n  in  1  NMI pin, asynchronous, active-low, edge-triggered.
- irq_n  in  1  IRQ pin, asynchronous, active-low, level-triggered.
- iFlag  in  1  processor I flag; 1 masks IRQ.
- decodedInstruction  in  6  decoder instruction code.
- decodedAddress  in  4  decoder addressing code.
- instructionOut  out  6  instruction code to `state_machine`.
- addressOut  out  4  addressing code to `state_machine`.
- vectorSel  out  2  0 = none, 1 = RESET (FFFC), 2 = NMI (FFFA), 3 = IRQ/BRK (FFFE).
- serviceActive  out  1  high while an interrupt or BRK sequence is executing.
- suppressPC  out  1  1 = do not increment PC on the opcode fetch (hardware interrupts).
- suppressWrite  out  1  1 = convert stack pushes to reads (RESET only).
- bFlag  out  1  B value to push: 1 = BRK, 0 = hardware.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset values:
  - All synchroniser flops = 1; nmiPending = 0; resetPending = 1.
  - serviceActive = 0; vectorSel = 0; suppressPC = 0; suppressWrite = 0; bFlag = 0.
  - State = RUN.
- Synchronisers and NMI edge detect:
  - Always clock, independent of `enableFFs`.
  - nmiPending sets on a synced 1->0 transition of `nmi_n`. This happens even while stalled; edges are never lost.
- irqReq = ~irq_sync & ~iFlag. It is combinational and not latched: if IRQ is deasserted before a boundary, it is dropped.
- accept = getInstruction & enableFFs.
- Priority at accept: resetPending > nmiPending > irqReq > (decodedInstruction == BRK_CODE) > normal.
- States:
  - RUN: no service in progress.
  - SERVICE: a service is in progress.
  - RUN -> SERVICE on accept with any of the four service sources selected.
  - SERVICE -> RUN on accept with no source selected.
  - SERVICE -> SERVICE on accept with a new source selected. Back-to-back services are allowed, e.g. an NMI queued behind an IRQ.
- Combinational outputs:
  - instructionOut/addressOut = INT_INSTR/INT_ADDR when accept and a hardware source (RESET/NMI/IRQ) is selected.
  - Otherwise they equal decodedInstruction/decodedAddress. BRK passes through unmodified.
- Registered on accept (held otherwise):
  - vectorSel = source code (0 if normal).
  - serviceActive = (source != normal).
  - suppressPC = hardware source.
  - suppressWrite = RESET.
  - bFlag = BRK.
- Clearing on accept:
  - resetPending clears on a RESET accept.
  - nmiPending clears on an NMI accept.
  - If a new NMI edge is detected in the same cycle as an NMI accept, nmiPending stays 1.
- Stall: with `enableFFs` = 0, all state except the synchronisers and NMI edge detect holds. Outputs stay at their registered values; the pass-through mux still operates.
- Reset mid-service: `rst` forces the reset values immediately. The first boundary after reset performs the RESET service.
- Latency:
  - NMI pin to pending: SYNC_STAGES + 1 clocks.
  - Pending to substitution: the next accept.

Optional Feature:
- Macro: INT_COUNT_EN.
- Defined:
  - Adds output port `intCount [7:0]`, reset 0.
  - Increments on each accept selecting a hardware source (RESET, NMI, IRQ).
  - Saturates at 8'hFF.
  - Holds when stalled.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Release `rst`, then assert getInstruction=1 with enableFFs=1 -> instructionOut=INT_INSTR, addressOut=INT_ADDR; next cycle vectorSel=1, suppressWrite=1, suppressPC=1, serviceActive=1.
- Pulse `nmi_n` low for 1 cycle mid-instruction with enableFFs=0 for 5 cycles, then boundary with enableFFs=1 -> vectorSel=2, bFlag=0; a second boundary with no sources -> serviceActive=0, vectorSel=0.
- Hold `irq_n`=0 with iFlag=1 across a boundary -> pass-through, vectorSel=0. With iFlag=0 -> vectorSel=3, suppressPC=1. Raise `irq_n` before the boundary -> no service.
- NMI edge and `irq_n` low at the same boundary -> NMI taken (vectorSel=2); next boundary -> IRQ taken (vectorSel=3) with serviceActive held at 1 throughout.
- decodedInstruction=BRK_CODE, no pending sources -> instructionOut=BRK_CODE, vectorSel=3, bFlag=1, suppressPC=0.
- INT_COUNT_EN defined: 300 IRQ services -> intCount=8'hFF; assert `rst` -> intCount=0.
